// File: rtl/spi_ram_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// spi_ram_pkg
// Shared definitions for the SPI/RAM arbiter slice:
//   - SPI command opcodes carried in spi_rx_data[9:8]
//   - access sequencer state encoding
//   - requester ids used by the round-robin arbiter and last_grant
// ----------------------------------------------------------------------------
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_t;

    // Requester ids double as bit positions in the arbiter req/grant vectors
    localparam logic REQ_SPI = 1'b0;
    localparam logic REQ_LOC = 1'b1;

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// ----------------------------------------------------------------------------
// spi_ram_arbiter_if
// Local-bus access port of the arbiter.
//   req    master->slave  level request, held until gnt
//   we     master->slave  1=write 0=read, stable while req
//   addr   master->slave  access address
//   wdata  master->slave  write data
//   gnt    slave->master  1-cycle pulse, access issued
//   rdata  slave->master  read data
//   rvalid slave->master  1-cycle pulse, rdata valid
// ----------------------------------------------------------------------------
interface spi_ram_arbiter_if #(
    parameter int ADDR_SIZE = 8
);
    logic                 req;
    logic                 we;
    logic [ADDR_SIZE-1:0] addr;
    logic [7:0]           wdata;
    logic                 gnt;
    logic [7:0]           rdata;
    logic                 rvalid;

    modport master (output req, we, addr, wdata, input gnt, rdata, rvalid);
    modport slave  (input req, we, addr, wdata, output gnt, rdata, rvalid);
endinterface

// File: rtl/spi_ram_arbiter_arb_rr2.sv
// ----------------------------------------------------------------------------
// arb_rr2
// Combinational two-requester round-robin arbiter.
//   req[1:0]    in   request vector, bit REQ_SPI / REQ_LOC
//   last_grant  in   id of the requester granted most recently
//   grant[1:0]  out  one-hot grant (all zero when nobody requests)
// On a tie the requester that was not granted last wins.
// ----------------------------------------------------------------------------
module arb_rr2
    import spi_ram_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == REQ_SPI) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// ----------------------------------------------------------------------------
// spi_ram_arbiter
// Owns the single RAM port and shares it between SPI command traffic and a
// local bus master. Decodes 10-bit SPI command words, keeps the SPI write/read
// address registers, holds one pending SPI access, and sequences RAM cycles.
//   clk, rst_n       clock, asynchronous active-low reset
//   spi_rx_data/valid  command word in ([9:8] opcode, [7:0] addr/data)
//   spi_tx_data/valid  SPI read result, valid held TX_HOLD cycles
//   spi_overrun        sticky: access command replaced a still-pending one
//   loc                local bus (slave side of spi_ram_arbiter_if)
//   ram_en/we/addr/wdata  registered RAM controls
//   ram_rdata          RAM read data, valid one edge after ram_en sampled
// ----------------------------------------------------------------------------
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256,
    parameter int TX_HOLD   = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           spi_rx_data,
    input  logic                 spi_rx_valid,
    output logic [7:0]           spi_tx_data,
    output logic                 spi_tx_valid,
    output logic                 spi_overrun,
    spi_ram_arbiter_if.slave     loc,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [7:0]           ram_wdata,
    input  logic [7:0]           ram_rdata
);

    localparam int CNT_W = $clog2(TX_HOLD + 1);

    if (ADDR_SIZE > 8 || MEM_DEPTH != (1 << ADDR_SIZE)) begin : g_bad_params
        $error("spi_ram_arbiter: ADDR_SIZE must be <= 8 and MEM_DEPTH == 2**ADDR_SIZE");
    end

    logic [1:0]           opcode;
    logic [ADDR_SIZE-1:0] rx_field;
    logic [7:0]           rx_byte;

    logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
    logic                 pend_valid, pend_we;
    logic [ADDR_SIZE-1:0] pend_addr;
    logic [7:0]           pend_wdata;

    state_t               state, state_nxt;
    logic [1:0]           arb_req, grant;
    logic                 last_grant;
    logic                 cur_we, cur_loc;
    logic [CNT_W-1:0]     tx_cnt;

    assign opcode   = spi_rx_data[9:8];
    assign rx_field = spi_rx_data[ADDR_SIZE-1:0];
    assign rx_byte  = spi_rx_data[7:0];

    // Requests are only looked at in IDLE; a local request withdrawn before
    // that simply never reaches the arbiter.
    assign arb_req = (state == ST_IDLE) ? {loc.req, pend_valid} : 2'b00;

    arb_rr2 u_arb (
        .req        (arb_req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Command decode, address registers and the single pending SPI access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr     <= '0;
            rd_addr     <= '0;
            pend_valid  <= 1'b0;
            pend_we     <= 1'b0;
            pend_addr   <= '0;
            pend_wdata  <= '0;
            spi_overrun <= 1'b0;
        end else begin
            if (grant[REQ_SPI])
                pend_valid <= 1'b0;
            // A capture on the grant edge wins over the clear above: the new
            // op becomes pending and waits for the next IDLE. The op being
            // granted on this edge is not counted as overrun.
            if (spi_rx_valid) begin
                case (opcode)
                    CMD_WR_ADDR: wr_addr <= rx_field;
                    CMD_RD_ADDR: rd_addr <= rx_field;
                    CMD_WR_DATA: begin
                        pend_valid <= 1'b1;
                        pend_we    <= 1'b1;
                        pend_addr  <= wr_addr;
                        pend_wdata <= rx_byte;
                        if (pend_valid && !grant[REQ_SPI])
                            spi_overrun <= 1'b1;
                    end
                    default: begin
                        pend_valid <= 1'b1;
                        pend_we    <= 1'b0;
                        pend_addr  <= rd_addr;
                        if (pend_valid && !grant[REQ_SPI])
                            spi_overrun <= 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (grant != 2'b00) state_nxt = ST_ACCESS;
            ST_ACCESS:  state_nxt = cur_we ? ST_IDLE : ST_RD_WAIT;
            ST_RD_WAIT: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // RAM drive, grant bookkeeping, read-data return and tx hold counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            last_grant   <= REQ_LOC;
            cur_we       <= 1'b0;
            cur_loc      <= 1'b0;
            loc.gnt      <= 1'b0;
            loc.rdata    <= '0;
            loc.rvalid   <= 1'b0;
            spi_tx_data  <= '0;
            spi_tx_valid <= 1'b0;
            tx_cnt       <= '0;
        end else begin
            ram_en     <= 1'b0;
            loc.gnt    <= 1'b0;
            loc.rvalid <= 1'b0;

            if (grant[REQ_SPI]) begin
                ram_en     <= 1'b1;
                ram_we     <= pend_we;
                ram_addr   <= pend_addr;
                ram_wdata  <= pend_wdata;
                cur_we     <= pend_we;
                cur_loc    <= 1'b0;
                last_grant <= REQ_SPI;
            end else if (grant[REQ_LOC]) begin
                ram_en     <= 1'b1;
                ram_we     <= loc.we;
                ram_addr   <= loc.addr;
                ram_wdata  <= loc.wdata;
                cur_we     <= loc.we;
                cur_loc    <= 1'b1;
                last_grant <= REQ_LOC;
                loc.gnt    <= 1'b1;
            end

            if (tx_cnt != '0) begin
                tx_cnt <= tx_cnt - CNT_W'(1);
                if (tx_cnt == CNT_W'(1))
                    spi_tx_valid <= 1'b0;
            end

            // A fresh SPI result reloads data and restarts the hold window
            if (state == ST_RD_WAIT) begin
                if (cur_loc) begin
                    loc.rdata  <= ram_rdata;
                    loc.rvalid <= 1'b1;
                end else begin
                    spi_tx_data  <= ram_rdata;
                    spi_tx_valid <= 1'b1;
                    tx_cnt       <= CNT_W'(TX_HOLD);
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_spi_ram_arbiter
// Scoreboard bench: stimulus pushes expected RAM accesses and read results into
// queues; monitors pop and compare whenever the DUT presents them.
// RAM model is initialised to mem[i] = i ^ 8'h5A.
// ----------------------------------------------------------------------------
module tb_spi_ram_arbiter;
    import spi_ram_pkg::*;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } ram_op_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] spi_rx_data = '0;
    logic       spi_rx_valid = 1'b0;
    logic [7:0] spi_tx_data;
    logic       spi_tx_valid;
    logic       spi_overrun;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_wdata;
    logic [7:0] ram_rdata = '0;
    logic [7:0] mem [0:255];

    spi_ram_arbiter_if #(.ADDR_SIZE(8)) bus ();

    spi_ram_arbiter #(.ADDR_SIZE(8), .MEM_DEPTH(256), .TX_HOLD(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_rx_data  (spi_rx_data),
        .spi_rx_valid (spi_rx_valid),
        .spi_tx_data  (spi_tx_data),
        .spi_tx_valid (spi_tx_valid),
        .spi_overrun  (spi_overrun),
        .loc          (bus),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    ram_op_t    exp_ram [$];
    logic [7:0] exp_spi [$];
    logic [7:0] exp_loc [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    logic prev_tx = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_en) begin
                if (exp_ram.size() == 0) begin
                    check("ram_unexpected_access", {ram_we, ram_addr}, 32'hFFFF);
                end else begin
                    ram_op_t e;
                    e = exp_ram.pop_front();
                    check("ram_we", ram_we, e.we);
                    check("ram_addr", ram_addr, e.addr);
                    if (e.we) check("ram_wdata", ram_wdata, e.wdata);
                end
            end
            if (spi_tx_valid && !prev_tx) begin
                if (exp_spi.size() == 0) check("spi_tx_unexpected", spi_tx_data, 32'h100);
                else check("spi_tx_data", spi_tx_data, exp_spi.pop_front());
            end
            if (bus.rvalid) begin
                if (exp_loc.size() == 0) check("loc_rvalid_unexpected", bus.rdata, 32'h100);
                else check("loc_rdata", bus.rdata, exp_loc.pop_front());
            end
        end
        prev_tx = spi_tx_valid;
    end

    // ---------------- stimulus helpers ----------------
    function automatic ram_op_t op(input logic we, input logic [7:0] a, input logic [7:0] d);
        op = '{we: we, addr: a, wdata: d};
    endfunction

    // Called just after an active edge; returns just after the capture edge
    task automatic spi_cmd(input logic [1:0] opc, input logic [7:0] d);
        spi_rx_data  = {opc, d};
        spi_rx_valid = 1'b1;
        @(posedge clk); #1;
        spi_rx_valid = 1'b0;
    endtask

    // Raises loc.req and waits for gnt; returns just after the gnt edge with req dropped
    task automatic loc_request(input logic we, input logic [7:0] a, input logic [7:0] d,
                               output int edges);
        bus.req = 1'b1; bus.we = we; bus.addr = a; bus.wdata = d;
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            edges++;
            if (bus.gnt) break;
        end
        check("loc_gnt_seen", bus.gnt, 1'b1);
        bus.req = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, seen;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;

        // Reset state
        #2;
        check("reset_outputs",
              {spi_tx_data, spi_tx_valid, spi_overrun, ram_en, ram_we, ram_addr, ram_wdata,
               bus.gnt, bus.rvalid}, 32'h0);
        check("reset_loc_rdata", bus.rdata, 8'h00);
        do_reset();

        // 1: asynchronous reset in RD_WAIT
        exp_ram.push_back(op(1'b0, 8'h07, 8'h00));
        spi_cmd(CMD_RD_ADDR, 8'h07);
        spi_cmd(CMD_RD_DATA, 8'h00);
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t1_ram_addr_cleared", ram_addr, 8'h00);
        check("t1_outputs_zero",
              {spi_tx_data, spi_tx_valid, spi_overrun, ram_en, ram_we, ram_wdata,
               bus.gnt, bus.rvalid}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (spi_tx_valid) seen++;
        end
        check("t1_no_tx_after_reset", seen, 0);

        // 6a: read with no prior address command -> addr 0
        exp_ram.push_back(op(1'b0, 8'h00, 8'h00));
        exp_spi.push_back(8'h5A);
        spi_cmd(CMD_RD_DATA, 8'h00);
        repeat (16) @(posedge clk); #1;

        // 2: SPI write then read back, latency and hold time
        exp_ram.push_back(op(1'b1, 8'h05, 8'hA5));
        exp_ram.push_back(op(1'b0, 8'h05, 8'h00));
        exp_spi.push_back(8'hA5);
        spi_cmd(CMD_WR_ADDR, 8'h05);
        spi_cmd(CMD_WR_DATA, 8'hA5);
        spi_cmd(CMD_RD_ADDR, 8'h05);
        spi_cmd(CMD_RD_DATA, 8'h00);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("t2_tx_valid_edge%0d", k), spi_tx_valid, (k == 3));
        end
        n = 1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (spi_tx_valid) n++;
            else break;
        end
        check("t2_tx_hold_cycles", n, 10);
        repeat (4) @(posedge clk); #1;

        // 3: local write then local read
        exp_ram.push_back(op(1'b1, 8'h10, 8'h3C));
        loc_request(1'b1, 8'h10, 8'h3C, n);
        @(posedge clk); #1;
        check("t3_gnt_pulse", bus.gnt, 1'b0);
        exp_ram.push_back(op(1'b0, 8'h10, 8'h00));
        exp_loc.push_back(8'h3C);
        loc_request(1'b0, 8'h10, 8'h00, n);
        @(posedge clk); #1;
        check("t3_rvalid_edge1", bus.rvalid, 1'b0);
        @(posedge clk); #1;
        check("t3_rvalid_edge2", bus.rvalid, 1'b1);
        repeat (4) @(posedge clk); #1;

        // 6b: read of the last word
        exp_ram.push_back(op(1'b0, 8'hFF, 8'h00));
        exp_spi.push_back(8'hA5);
        spi_cmd(CMD_RD_ADDR, 8'hFF);
        spi_cmd(CMD_RD_DATA, 8'h00);
        repeat (16) @(posedge clk); #1;

        // 4: ties after reset -> SPI first, then alternate
        do_reset();
        exp_ram.push_back(op(1'b0, 8'h20, 8'h00));
        exp_ram.push_back(op(1'b0, 8'h30, 8'h00));
        exp_spi.push_back(8'h7A);
        exp_loc.push_back(8'h6A);
        spi_cmd(CMD_RD_ADDR, 8'h20);
        spi_cmd(CMD_RD_DATA, 8'h00);
        loc_request(1'b0, 8'h30, 8'h00, n);
        check("t4_tie1_loc_waits", n, 4);
        repeat (16) @(posedge clk); #1;

        exp_ram.push_back(op(1'b1, 8'h40, 8'h11));
        spi_cmd(CMD_WR_ADDR, 8'h40);
        spi_cmd(CMD_WR_DATA, 8'h11);
        repeat (4) @(posedge clk); #1;
        exp_ram.push_back(op(1'b0, 8'h31, 8'h00));
        exp_ram.push_back(op(1'b0, 8'h20, 8'h00));
        exp_loc.push_back(8'h6B);
        exp_spi.push_back(8'h7A);
        spi_cmd(CMD_RD_DATA, 8'h00);
        loc_request(1'b0, 8'h31, 8'h00, n);
        check("t4_tie2_loc_first", n, 1);
        repeat (16) @(posedge clk); #1;

        // 5: overrun while the RAM is busy with a local read
        check("t5_overrun_before", spi_overrun, 1'b0);
        spi_cmd(CMD_RD_ADDR, 8'h60);
        exp_ram.push_back(op(1'b0, 8'h50, 8'h00));
        exp_ram.push_back(op(1'b0, 8'h60, 8'h00));
        exp_loc.push_back(8'h0A);
        exp_spi.push_back(8'h3A);
        loc_request(1'b0, 8'h50, 8'h00, n);
        spi_cmd(CMD_RD_DATA, 8'h00);
        spi_cmd(CMD_RD_DATA, 8'h00);
        check("t5_overrun_set", spi_overrun, 1'b1);
        repeat (20) @(posedge clk); #1;
        check("t5_overrun_sticky", spi_overrun, 1'b1);

        // Everything expected must have been observed
        check("ram_queue_drained", exp_ram.size(), 0);
        check("spi_queue_drained", exp_spi.size(), 0);
        check("loc_queue_drained", exp_loc.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
